// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad front end: raw button vector, encoded key, debounce states.
package calc_pkg;

    typedef struct packed {
        logic       off;
        logic       on;
        logic       clr;
        logic       eq;
        logic       div;
        logic       mul;
        logic       sub;
        logic       add;
        logic [9:0] num;
    } buttons_t;

    typedef enum logic [4:0] {
        B_NONE,
        B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
        B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
        B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ,
        B_CLR, B_ON, B_OFF
    } active_button_t;

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} btn_state_e;

    // OFF wins over ON, ON wins over everything else; any other chord is no key at all.
    function automatic active_button_t buttons2active(buttons_t b);
        logic [15:0]    others;
        active_button_t r;
        others = {b.clr, b.eq, b.div, b.mul, b.sub, b.add, b.num};
        r = B_NONE;
        if (b.off) begin
            r = B_OFF;
        end else if (b.on) begin
            r = B_ON;
        end else if ($countones(others) == 1) begin
            for (int i = 0; i < 10; i++)
                if (b.num[i]) r = active_button_t'(5'(i + 1));
            if (b.add) r = B_OP_ADD;
            if (b.sub) r = B_OP_SUB;
            if (b.mul) r = B_OP_MUL;
            if (b.div) r = B_OP_DIV;
            if (b.eq)  r = B_OP_EQ;
            if (b.clr) r = B_CLR;
        end
        return r;
    endfunction

    function automatic logic is_digit(active_button_t b);
        return (b >= B_NUM_0) && (b <= B_NUM_9);
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
module button_sync #(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    logic [Width-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Keypad debouncer: sync, encode, debounce FSM and a one-entry press event buffer.
// Define CALC_BUTTON_REPEAT_EN to add auto-repeat of held digit keys.
module button_debouncer
    import calc_pkg::*;
#(
    parameter int DebounceCycles = 1000
`ifdef CALC_BUTTON_REPEAT_EN
    ,
    parameter int RepeatDelayCycles  = 500000,
    parameter int RepeatPeriodCycles = 100000
`endif
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  buttons_t       buttons_i,
    output logic           press_valid_o,
    output active_button_t press_button_o,
    input  logic           press_ready_i,
    output logic           held_o,
    output logic           overrun_o
);

    localparam int CW = $clog2(DebounceCycles + 1);
    localparam logic [CW-1:0] CntMax = CW'(DebounceCycles);

    logic [$bits(buttons_t)-1:0] sync_q;
    active_button_t sample;
    btn_state_e     state, state_n;
    active_button_t cand, cand_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           emit;
    logic           rpt_hit;

    button_sync #(.Width($bits(buttons_t))) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (buttons_i),
        .dout (sync_q)
    );

    assign sample = buttons2active(buttons_t'(sync_q));

`ifdef CALC_BUTTON_REPEAT_EN
    localparam int RptMax = (RepeatDelayCycles > RepeatPeriodCycles) ? RepeatDelayCycles
                                                                     : RepeatPeriodCycles;
    localparam int RW = $clog2(RptMax + 1);
    logic [RW-1:0] rpt;
    logic          rpt_first;

    // First repeat waits the long delay, later ones the period; both end on limit-1 so the
    // event lands in the buffer exactly on the limit edge.
    assign rpt_hit = (state == S_HELD) && is_digit(cand) && (sample == cand) &&
                     (rpt == (rpt_first ? RW'(RepeatDelayCycles - 1) : RW'(RepeatPeriodCycles - 1)));

    always_ff @(posedge clk_i) begin
        if (rst_i || state != S_HELD || !is_digit(cand)) begin
            rpt       <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_hit) begin
            rpt       <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt <= rpt + RW'(1);
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cand  <= B_NONE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        emit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample != B_NONE) begin
                    state_n = S_DEBOUNCE;
                    cand_n  = sample;
                    cnt_n   = CW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (sample == cand) begin
                    if (cnt == CntMax) begin
                        state_n = S_HELD;
                        emit    = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else if (sample == B_NONE) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cand_n = sample;
                    cnt_n  = CW'(1);
                end
            end
            S_HELD: begin
                // Any change, including a chord containing cand, counts as letting go.
                if (sample != cand) begin
                    state_n = S_RELEASE;
                    cnt_n   = CW'(1);
                end else if (rpt_hit) begin
                    emit = 1'b1;
                end
            end
            S_RELEASE: begin
                if (sample == cand) begin
                    state_n = S_HELD;
                end else if (cnt == CntMax) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_valid_o  <= 1'b0;
            press_button_o <= B_NONE;
            overrun_o      <= 1'b0;
        end else if (emit) begin
            if (!press_valid_o || press_ready_i) begin
                press_valid_o  <= 1'b1;
                press_button_o <= cand;
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (press_valid_o && press_ready_i) begin
            press_valid_o  <= 1'b0;
            press_button_o <= B_NONE;
        end
    end

    assign held_o = (state == S_HELD) || (state == S_RELEASE);

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DebounceCycles=4; press events checked via scoreboard.
module tb_button_debouncer;
    import calc_pkg::*;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ready = 1'b1;
    buttons_t       btn = '0;
    logic           valid, held, overrun;
    active_button_t pbtn;

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    button_debouncer #(
        .DebounceCycles(D)
`ifdef CALC_BUTTON_REPEAT_EN
        ,
        .RepeatDelayCycles(10),
        .RepeatPeriodCycles(5)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .buttons_i      (btn),
        .press_valid_o  (valid),
        .press_button_o (pbtn),
        .press_ready_i  (ready),
        .held_o         (held),
        .overrun_o      (overrun)
    );

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        active_button_t b;
        int             e;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        buttons_t       b;
        active_button_t exp;
        bit             press;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    // Returns just after the given clock edge; inputs driven here are sampled on the next edge.
    task automatic at_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input active_button_t b, input int e);
        exp_t x;
        x.b = b;
        x.e = e;
        sb.push_back(x);
    endtask

    function automatic buttons_t num_key(input int i);
        buttons_t b;
        b = '0;
        b.num[i] = 1'b1;
        return b;
    endfunction

    // Scoreboard consumer: every accepted event must match the next expected press and edge.
    always @(negedge clk) begin
        exp_t x;
        if (valid && ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_press: got button %0d at edge %0d, none expected", pbtn, edge_n);
            end else begin
                x = sb.pop_front();
                chk("press_button", int'(pbtn), int'(x.b));
                chk("press_edge", edge_n, x.e);
            end
        end
        if (!valid) chk("idle_button_none", int'(pbtn), int'(B_NONE));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, s2, r;
        buttons_t b;

        tbl[0].b = num_key(5); tbl[0].exp = B_NUM_5;  tbl[0].press = 1'b1;
        tbl[1].b = num_key(0); tbl[1].exp = B_NUM_0;  tbl[1].press = 1'b1;
        b = '0; b.num[1] = 1'b1; b.num[2] = 1'b1;
        tbl[2].b = b;          tbl[2].exp = B_NONE;   tbl[2].press = 1'b0;
        b = '0; b.on = 1'b1; b.num[1] = 1'b1;
        tbl[3].b = b;          tbl[3].exp = B_ON;     tbl[3].press = 1'b1;
        b = '0; b.on = 1'b1; b.off = 1'b1;
        tbl[4].b = b;          tbl[4].exp = B_OFF;    tbl[4].press = 1'b1;
        b = '0; b.clr = 1'b1;
        tbl[5].b = b;          tbl[5].exp = B_CLR;    tbl[5].press = 1'b1;
        b = '0; b.sub = 1'b1; b.div = 1'b1;
        tbl[6].b = b;          tbl[6].exp = B_NONE;   tbl[6].press = 1'b0;

        rst = 1'b1;
        at_edge(2);
        chk("reset_valid", int'(valid), 0);
        chk("reset_button", int'(pbtn), int'(B_NONE));
        chk("reset_held", int'(held), 0);
        chk("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        at_edge(5);

        // Encode and basic press/release timing, one vector per physical press.
        for (int i = 0; i < 7; i++) begin
            s = edge_n + 1;
            btn = tbl[i].b;
            if (tbl[i].press) push(tbl[i].exp, s + D + 2);
            at_edge(s + D + 1);
            chk("held_before_accept", int'(held), 0);
            at_edge(s + D + 2);
            chk("held_after_accept", int'(held), int'(tbl[i].press));
            at_edge(s + 19);
            btn = '0;
            r = s + 20;
            at_edge(r + D + 1);
            chk("held_during_release", int'(held), int'(tbl[i].press));
            at_edge(r + D + 2);
            chk("held_after_release", int'(held), 0);
            at_edge(r + 10);
        end

        // Bouncing contact: only the final stable run is accepted.
        s = edge_n + 1;
        btn = num_key(3);
        at_edge(s + 1); btn = '0;
        at_edge(s + 3); btn = num_key(3);
        at_edge(s + 5); btn = '0;
        at_edge(s + 7); btn = num_key(3);
        push(B_NUM_3, s + 14);
        at_edge(s + 13);
        chk("bounce_held_early", int'(held), 0);
        at_edge(s + 14);
        chk("bounce_held", int'(held), 1);
        at_edge(s + 24); btn = '0;
        at_edge(s + 34);

        // Stalled consumer: second press is dropped, first stays put.
        ready = 1'b0;
        s = edge_n + 1;
        b = '0; b.add = 1'b1; btn = b;
        at_edge(s + D + 2);
        chk("stall_valid", int'(valid), 1);
        chk("stall_button", int'(pbtn), int'(B_OP_ADD));
        at_edge(s + 9); btn = '0;
        at_edge(s + 19);
        s2 = edge_n + 1;
        b = '0; b.eq = 1'b1; btn = b;
        at_edge(s2 + D + 1);
        chk("overrun_before_drop", int'(overrun), 0);
        at_edge(s2 + D + 2);
        chk("overrun_set", int'(overrun), 1);
        chk("stall_button_kept", int'(pbtn), int'(B_OP_ADD));
        chk("stall_valid_kept", int'(valid), 1);
        at_edge(s2 + 9); btn = '0;
        at_edge(s2 + 19);
        chk("stall_button_late", int'(pbtn), int'(B_OP_ADD));
        ready = 1'b1;
        push(B_OP_ADD, edge_n);
        at_edge(edge_n + 1);
        ready = 1'b0;
        chk("valid_after_accept", int'(valid), 0);
        chk("overrun_sticky", int'(overrun), 1);
        at_edge(edge_n + 3);
        ready = 1'b1;

        // Reset in the middle of a debounce; key held through it.
        s = edge_n + 1;
        btn = num_key(7);
        at_edge(s + 2); rst = 1'b1;
        at_edge(s + 3); rst = 1'b0;
        chk("midreset_overrun", int'(overrun), 0);
        chk("midreset_valid", int'(valid), 0);
        chk("midreset_held", int'(held), 0);
        push(B_NUM_7, s + 10);
        at_edge(s + 9);
        chk("midreset_held_early", int'(held), 0);
        at_edge(s + 10);
        chk("midreset_held_late", int'(held), 1);
        chk("midreset_overrun_late", int'(overrun), 0);
        at_edge(s + 20); btn = '0;
        at_edge(s + 32);

`ifdef CALC_BUTTON_REPEAT_EN
        // Held digit auto-repeats; held operator does not.
        s = edge_n + 1;
        btn = num_key(9);
        push(B_NUM_9, s + 6);
        for (int k = 0; k < 6; k++) push(B_NUM_9, s + 16 + 5 * k);
        at_edge(s + 39); btn = '0;
        at_edge(s + 55);
        s = edge_n + 1;
        b = '0; b.mul = 1'b1; btn = b;
        push(B_OP_MUL, s + 6);
        at_edge(s + 39); btn = '0;
        at_edge(s + 55);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input stage between raw keypad contacts and the calculator core.
- Synchronizes `calc_pkg::buttons_t` and debounces it.
- Resolves chords and emits one `calc_pkg::active_button_t` press event per physical press.
- The event is held in a one-entry valid/ready buffer that feeds the core's command decoder.

Parameters:
- DebounceCycles, 1000, consecutive stable sampled cycles required to accept a press or a release; must be >= 1.
- RepeatDelayCycles, 500000, HELD cycles before the first auto-repeat (used only with CALC_BUTTON_REPEAT_EN).
- RepeatPeriodCycles, 100000, cycles between subsequent auto-repeats (used only with CALC_BUTTON_REPEAT_EN).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- buttons_i  in  $bits(calc_pkg::buttons_t)  raw asynchronous button levels, one bit per key.
- press_valid_o  out  1  a press event is pending.
- press_button_o  out  $bits(calc_pkg::active_button_t)  pending key; B_NONE when press_valid_o=0.
- press_ready_i  in  1  consumer accepts the event.
- held_o  out  1  a debounced key is currently down (state HELD or RELEASE).
- overrun_o  out  1  sticky: a press was dropped because the buffer was full.

Behaviour:
- Reset values:
  - Sync flops = 0, state = IDLE, counters = 0.
  - press_valid_o = 0, press_button_o = B_NONE, held_o = 0, overrun_o = 0.
- Synchronizer: two flops on buttons_i. `sample` = encode(second flop stage).
- Encode rule:
  - off set -> B_OFF (beats on).
  - Else on set -> B_ON.
  - Else exactly one other bit set -> that key.
  - Else (zero bits or multi-hot chord) -> B_NONE.
- State machine, with `cand` register and `cnt` counter of width $clog2(DebounceCycles+1):
  - IDLE:
    - sample != B_NONE -> DEBOUNCE, cand = sample, cnt = 1.
  - DEBOUNCE:
    - sample == cand: cnt++. When cnt == DebounceCycles -> HELD and emit press(cand).
    - sample == B_NONE -> IDLE.
    - Other key -> stay in DEBOUNCE, cand = sample, cnt = 1.
  - HELD:
    - sample == cand -> stay.
    - Otherwise -> RELEASE, cnt = 1.
  - RELEASE:
    - sample == cand -> HELD (bounce; no new press).
    - Otherwise cnt++. When cnt == DebounceCycles -> IDLE.
- Latency: buttons_i stable one-hot from edge 0 gives press_valid_o high after edge 2+DebounceCycles.
- Output buffer:
  - Emit while press_valid_o=0: load on the next edge.
  - Emit while press_valid_o=1 and press_ready_i=1 on the same cycle: new event replaces the old one, press_valid_o stays 1, no overrun.
  - Emit while press_valid_o=1 and press_ready_i=0: new event is dropped, overrun_o set.
  - Handshake with no emit: press_valid_o drops next cycle.
  - press_button_o is stable while press_valid_o=1 and press_ready_i=0.
- overrun_o clears only on rst_i.
- Reset mid-operation: all state is discarded. A key still held after reset is re-debounced from IDLE and produces a press.
- A chord during HELD counts as a change away from cand, so it goes to RELEASE. An ON/OFF chord can therefore interrupt a held digit.

Optional Feature:
- CALC_BUTTON_REPEAT_EN defined:
  - In HELD, with cand in B_NUM_0..B_NUM_9, a repeat counter runs.
  - Extra press(cand) after RepeatDelayCycles in HELD, then every RepeatPeriodCycles.
  - Leaving HELD or a RELEASE bounce resets the repeat counter.
  - Repeats follow the same buffer and overrun rules.
- Undefined: exactly one press per HELD entry. No repeat counter logic or repeat parameters are used.

Decomposition:
- calc_pkg:
  - buttons_t, active_button_t (including B_NONE).
  - debounce state enum btn_state_e {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE}.
  - function buttons2active(buttons_t) implementing the encode rule.
- Sub-module: button_sync, a parameterized-width two-flop synchronizer with synchronous active-high reset.

Test Plan (DebounceCycles=4, press_ready_i=1 unless stated):
1. num_5 asserted at edge 0, held 20 cycles -> exactly one press_valid_o pulse carrying B_NUM_5, visible after edge 6; held_o=1; after release held_o falls 2+4 cycles later.
2. num_3 toggles 1,0,1,0 every 2 cycles, then steady 1 from edge 8 -> single B_NUM_3 press after edge 14; nothing earlier.
3. num_1+num_2 held 20 cycles -> no press, held_o=0; on+num_1 -> one B_ON press; on+off -> one B_OFF press.
4. press_ready_i=0: press op_add (release), then op_eq -> press_button_o stays B_OP_ADD, overrun_o=1. Then press_ready_i=1 for one cycle -> press_valid_o=0 next cycle, overrun_o still 1.
5. rst_i pulsed at edge 3 of a num_7 debounce, key held -> no press before reset. After reset release, B_NUM_7 press 6 edges later, overrun_o=0.
6. CALC_BUTTON_REPEAT_EN, RepeatDelayCycles=10, RepeatPeriodCycles=5, num_9 held 40 cycles -> B_NUM_9 presses after edges 6, 16, 21, 26, 31, 36, 41. Op_mul held the same way -> one press only.
